// File: rtl/hex_ctrl_pkg.sv
// Shared types and constants for the hex display refresh scheduler.
//   seg_t        7-bit active-low segment vector, bit0=a .. bit6=g
//   SEG_BLANK    all segments off
//   state_t      scheduler states IDLE / SCAN
//   GLYPH_TABLE  active-low hex glyphs 0..F
package hex_ctrl_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam seg_t GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex-to-7-segment decoder (active-low glyphs).
//   i_digit  in   4  hex nibble
//   o_seg    out  7  segment pattern, bit0=a .. bit6=g, 0 = lit
module hex7_decode
    import hex_ctrl_pkg::*;
(
    input  logic [3:0] i_digit,
    output seg_t       o_seg
);

    assign o_seg = GLYPH_TABLE[i_digit];

endmodule

// File: rtl/hex_refresh_sched.sv
// Time-multiplexed refresh of NUM_DIGITS hex displays through one shared decoder.
// Writers update digit registers; a scheduler walks the slots one per cycle and
// latches decoded glyphs into per-display segment registers. A free-running timer
// forces a full repaint every REFRESH_DIV cycles.
//   clk        in   1               rising-edge clock
//   resetn     in   1               asynchronous active-low reset
//   wr_valid   in   1               write request
//   wr_ready   out  1               low only while the requested slot is being scanned
//   wr_idx     in   3               target slot (>= NUM_DIGITS accepted and ignored)
//   wr_data    in   4               hex nibble
//   en         in   1               0 blanks every display
//   hex_flat   out  7*NUM_DIGITS    slot i at [7i+6:7i], active-low
//   pass_done  out  1               one-cycle pulse after each completed scan pass
// Build option: define BLANK_LEADING_ZERO_EN to blank leading zeros (slot 0 always shown).
module hex_refresh_sched
    import hex_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [2:0]              wr_idx,
    input  logic [3:0]              wr_data,
    input  logic                    en,
    output logic [7*NUM_DIGITS-1:0] hex_flat,
    output logic                    pass_done
);

    localparam int              TW         = $clog2(REFRESH_DIV);
    localparam logic [2:0]      LAST_PTR   = 3'(NUM_DIGITS - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(REFRESH_DIV - 1);

    state_t                  r_state;
    logic [2:0]              r_ptr;
    logic                    r_full;
    logic                    r_full_req;
    logic                    r_pass_done;
    logic [TW-1:0]           r_timer;
    logic [3:0]              r_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   r_dirty;
    logic [7*NUM_DIGITS-1:0] r_seg;

    logic                    w_wr_acc;
    logic                    w_timer_tc;
    logic [3:0]              w_cur_digit;
    logic                    w_cur_dirty;
    seg_t                    w_glyph;
    seg_t                    w_cur_seg;
    logic [NUM_DIGITS-1:0]   w_wr_dirty;

    // Only the slot under the scan pointer is protected; every other write proceeds.
    assign wr_ready   = !((r_state == SCAN) && (wr_idx == r_ptr));
    assign w_wr_acc   = wr_valid && wr_ready;
    assign w_timer_tc = (r_timer == TIMER_LAST);

    always_comb begin
        w_cur_digit = 4'h0;
        w_cur_dirty = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_ptr == 3'(i)) begin
                w_cur_digit = r_digit[i];
                w_cur_dirty = r_dirty[i];
            end
        end
    end

    hex7_decode u_decode (
        .i_digit (w_cur_digit),
        .o_seg   (w_glyph)
    );

`ifdef BLANK_LEADING_ZERO_EN
    logic w_upper_nonzero;

    // Slot ptr is a leading zero when it and every higher slot hold 0.
    always_comb begin
        w_upper_nonzero = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((3'(j) >= r_ptr) && (r_digit[j] != 4'h0)) begin
                w_upper_nonzero = 1'b1;
            end
        end
    end

    assign w_cur_seg = ((r_ptr != 3'd0) && !w_upper_nonzero) ? SEG_BLANK : w_glyph;

    // Lower slots' blanking depends on the written digit, so they are repainted too.
    always_comb begin
        w_wr_dirty = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((3'(i) <= wr_idx) && (wr_idx <= LAST_PTR)) begin
                w_wr_dirty[i] = 1'b1;
            end
        end
    end
`else
    assign w_cur_seg = w_glyph;

    always_comb begin
        w_wr_dirty = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_idx == 3'(i)) begin
                w_wr_dirty[i] = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_ptr       <= 3'd0;
            r_full      <= 1'b0;
            r_full_req  <= 1'b0;
            r_pass_done <= 1'b0;
            r_timer     <= '0;
            r_dirty     <= '1;
            r_seg       <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= 4'h0;
            end
        end else begin
            r_pass_done <= 1'b0;
            r_timer     <= w_timer_tc ? '0 : r_timer + 1'b1;
            if (w_timer_tc) begin
                r_full_req <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if ((|r_dirty) || r_full_req) begin
                        r_state    <= SCAN;
                        r_ptr      <= 3'd0;
                        r_full     <= r_full_req;
                        // A terminal count landing now must not be lost.
                        r_full_req <= w_timer_tc;
                    end
                end
                SCAN: begin
                    if (w_cur_dirty || r_full) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (r_ptr == 3'(i)) begin
                                r_seg[7*i +: 7] <= w_cur_seg;
                                r_dirty[i]      <= 1'b0;
                            end
                        end
                    end
                    if (r_ptr == LAST_PTR) begin
                        r_state     <= IDLE;
                        r_ptr       <= 3'd0;
                        r_pass_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Placed after the scan clear so a new write always re-arms its slots.
            if (w_wr_acc) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (w_wr_dirty[i]) begin
                        r_dirty[i] <= 1'b1;
                    end
                    if (wr_idx == 3'(i)) begin
                        r_digit[i] <= wr_data;
                    end
                end
            end
        end
    end

    assign hex_flat  = en ? r_seg : '1;
    assign pass_done = r_pass_done;

endmodule
